// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download sequencer: FSM states,
// download region tags, region address map and default image size.
package rom_load_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RGN_CPU  = 2'd0,
    RGN_GFX  = 2'd1,
    RGN_SND  = 2'd2,
    RGN_NONE = 2'd3
  } region_e;

  localparam int unsigned CPU_BASE_DEF  = 32'h0_0000;
  localparam int unsigned GFX_BASE_DEF  = 32'h0_8000;
  localparam int unsigned SND_BASE_DEF  = 32'h1_4000;
  localparam int unsigned SND_LIMIT_DEF = 32'h1_7FFF;
  localparam int unsigned ROM_BYTES_DEF = 32'h1_8000;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational ioctl byte address -> download region tag and in-range flag.
// Zero latency; no flow control (pure decode).
module rom_region_dec
  import rom_load_pkg::*;
#(
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEF,
  parameter int unsigned GFX_BASE  = GFX_BASE_DEF,
  parameter int unsigned SND_BASE  = SND_BASE_DEF
) (
  input  logic [24:0] addr_i,
  output region_e     region_o,
  output logic        in_range_o
);

  logic [31:0] addr_ext;
  assign addr_ext = {7'd0, addr_i};

  always_comb begin
    in_range_o = (addr_ext < ROM_BYTES);
    region_o   = RGN_NONE;
    if (in_range_o) begin
      if (addr_ext >= SND_BASE)      region_o = RGN_SND;
      else if (addr_ext >= GFX_BASE) region_o = RGN_GFX;
      else                           region_o = RGN_CPU;
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: registers qualified ioctl writes onto the core download
// port (1-cycle latency, no bubbles), holds core reset until a full image plus
// HOLD_CYCLES has passed. No backpressure. ROM_LOAD_CHECKSUM_EN adds a byte-sum check.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned ROM_BYTES    = ROM_BYTES_DEF,
  parameter int unsigned HOLD_CYCLES  = 4096,
  parameter logic [15:0] EXPECTED_SUM = 16'h0000,
  parameter int unsigned GFX_BASE     = GFX_BASE_DEF,
  parameter int unsigned SND_BASE     = SND_BASE_DEF
) (
  input  logic              clk_sys_i,
  input  logic              reset_i,
  input  logic              ioctl_download_i,
  input  logic              ioctl_wr_i,
  input  logic [24:0]       ioctl_addr_i,
  input  logic [7:0]        ioctl_dout_i,
  input  logic              user_reset_i,
  output logic [ADDR_W-1:0] dn_addr_o,
  output logic [7:0]        dn_data_o,
  output logic              dn_wr_o,
  output logic [1:0]        dn_region_o,
  output logic              core_reset_o,
  output logic              load_ok_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   byte_count_o,
  output logic [15:0]       rom_sum_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   ROM_CNT   = (ADDR_W + 1)'(ROM_BYTES);

  state_e            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [ADDR_W-1:0] dn_addr_q;
  logic [7:0]        dn_data_q;
  logic              dn_wr_q;
  region_e           dn_region_q;
  logic              core_reset_q;
  logic              load_ok_q;
  logic              load_err_q;
  logic [ADDR_W:0]   byte_count_q;
  logic [ADDR_W:0]   byte_count_d;
  logic              ovf_q;

  region_e region;
  logic    in_range;
  logic    wr_vld;
  logic    acc;
  logic    enter_load;
  logic    sum_ok;
  logic    verdict;

  rom_region_dec #(
    .ROM_BYTES (ROM_BYTES),
    .GFX_BASE  (GFX_BASE),
    .SND_BASE  (SND_BASE)
  ) u_dec (
    .addr_i     (ioctl_addr_i),
    .region_o   (region),
    .in_range_o (in_range)
  );

  // A strobe in the cycle the download window drops is never qualified.
  assign wr_vld       = ioctl_download_i & ioctl_wr_i & (state_q == ST_LOAD);
  assign acc          = wr_vld & in_range;
  assign enter_load   = ioctl_download_i & (state_q != ST_LOAD);
  assign byte_count_d = (&byte_count_q) ? byte_count_q : byte_count_q + 1'b1;

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] rom_sum_q;
  always_ff @(posedge clk_sys_i) begin
    if (reset_i || enter_load) rom_sum_q <= '0;
    else if (acc)              rom_sum_q <= rom_sum_q + {8'd0, ioctl_dout_i};
  end
  assign sum_ok    = (rom_sum_q == EXPECTED_SUM);
  assign rom_sum_o = rom_sum_q;
`else
  assign sum_ok    = 1'b1;
  assign rom_sum_o = '0;
`endif

  assign verdict = (byte_count_q == ROM_CNT) & ~ovf_q & sum_ok;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q      <= ST_WAIT;
      hold_cnt_q   <= '0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      dn_region_q  <= RGN_CPU;
      core_reset_q <= 1'b1;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      dn_wr_q      <= acc;
      core_reset_q <= 1'b1;
      if (acc) begin
        dn_addr_q   <= ioctl_addr_i[ADDR_W-1:0];
        dn_data_q   <= ioctl_dout_i;
        dn_region_q <= region;
      end
      if (enter_load) begin
        state_q      <= ST_LOAD;
        byte_count_q <= '0;
        ovf_q        <= 1'b0;
        load_ok_q    <= 1'b0;
        load_err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (acc)               byte_count_q <= byte_count_d;
            if (wr_vld & ~in_range) ovf_q       <= 1'b1;
            if (!ioctl_download_i) begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= '0;
              load_ok_q  <= verdict;
              load_err_q <= ~verdict;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q      <= ST_RUN;
              core_reset_q <= user_reset_i;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          ST_RUN:  core_reset_q <= user_reset_i;
          default: ;
        endcase
      end
    end
  end

  assign dn_addr_o    = dn_addr_q;
  assign dn_data_o    = dn_data_q;
  assign dn_wr_o      = dn_wr_q;
  assign dn_region_o  = dn_region_q;
  assign core_reset_o = core_reset_q;
  assign load_ok_o    = load_ok_q;
  assign load_err_o   = load_err_q;
  assign byte_count_o = byte_count_q;

endmodule
